// File: rtl/usb_pkg.sv
// Shared USB receive-path types and constants: FSM states, PID codes, CRC-16 parameters.
package usb_pkg;

  typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_SKIP, S_CHECK} state_t;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;

  typedef struct packed {
    logic is_data;
    logic data_pid;
    logic crc_ok;
    logic crc_err;
    logic pid_err;
    logic len_err;
  } verdict_t;

  // A PID is well-formed when its upper nibble is the complement of the lower one.
  function automatic logic pid_nibble_ok(input logic [7:0] p);
    return p[3:0] == ~p[7:4];
  endfunction

endpackage

// File: rtl/usb_rx_crc_ctrl_if.sv
// Bit-stream in / packet-verdict out bundle between the unstuffer and the CRC sequencer.
interface usb_rx_crc_ctrl_if #(parameter int MAX_BYTES = 1026);
  localparam int BCW = $clog2(MAX_BYTES + 1);

  logic           sop;
  logic           eop;
  logic           rx_bit_valid;
  logic           rx_bit;
  logic           pkt_done;
  logic           is_data;
  logic           data_pid;
  logic           crc_ok;
  logic           crc_err;
  logic           pid_err;
  logic           len_err;
  logic [BCW-1:0] byte_cnt;

  modport master (
    output sop, eop, rx_bit_valid, rx_bit,
    input  pkt_done, is_data, data_pid, crc_ok, crc_err, pid_err, len_err, byte_cnt
  );

  modport slave (
    input  sop, eop, rx_bit_valid, rx_bit,
    output pkt_done, is_data, data_pid, crc_ok, crc_err, pid_err, len_err, byte_cnt
  );
endinterface

// File: rtl/usb_rx_crc_ctrl_crc16.sv
// Bit-serial USB CRC-16 residual checker (x^16+x^15+x^2+1), MSB-side feedback.
module USB_crc_16
  import usb_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic crc_clear,
  input  logic shift_enable,
  input  logic d_orig,
  output logic crc_check_16
);
  logic [15:0] crc;
  logic        fb;

  assign fb = crc[15] ^ d_orig;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            crc <= CRC16_INIT;
    else if (crc_clear)    crc <= CRC16_INIT;
    else if (shift_enable) crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

  assign crc_check_16 = (crc == CRC16_RESIDUAL);
endmodule

// File: rtl/usb_rx_crc_ctrl.sv
// Receive-side CRC-16 sequencer: frames packets, decodes PID, gates the LFSR, reports verdicts.
module usb_rx_crc_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 1026
) (
  input  logic              clk,
  input  logic              rst,
  usb_rx_crc_ctrl_if.slave  bus
);
  localparam int          BCW      = $clog2(MAX_BYTES + 1);
  localparam logic [13:0] MAX_BITS = 14'(8 * MAX_BYTES);

  state_t         state, state_n;
  logic [13:0]    bit_cnt;
  logic [6:0]     pid_sr;
  logic [2:0]     pid_cnt;
  logic           ovf, w_pid_err, w_is_data, w_data_pid;
  logic           crc_clear, shift_enable, crc_check_16;
  logic [7:0]     pid_full;
  logic [10:0]    bytes_raw;
  verdict_t       vd, vd_n;
  logic [BCW-1:0] bcnt, bcnt_n;
  logic           bit_in;

  assign pid_full  = {bus.rx_bit, pid_sr};
  assign bytes_raw = bit_cnt[13:3];
  assign bit_in    = bus.rx_bit_valid && !bus.eop;

  always_comb begin
    state_n      = state;
    crc_clear    = 1'b0;
    shift_enable = 1'b0;
    case (state)
      S_IDLE: begin
        crc_clear = 1'b1;
        if (bus.sop) state_n = S_PID;
      end
      S_PID: begin
        if (bus.eop) state_n = S_CHECK;
        else if (bus.rx_bit_valid && pid_cnt == 3'd7)
          state_n = (pid_nibble_ok(pid_full) &&
                     (pid_full == PID_DATA0 || pid_full == PID_DATA1)) ? S_DATA : S_SKIP;
      end
      S_DATA: begin
        if (bus.eop) state_n = S_CHECK;
        else if (bus.rx_bit_valid && !ovf && bit_cnt < MAX_BITS) shift_enable = 1'b1;
      end
      S_SKIP:  if (bus.eop) state_n = S_CHECK;
      S_CHECK: begin
        crc_clear = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // A new sop anywhere mid-packet drops the old one without a verdict.
    if (bus.sop && state != S_IDLE) begin
      state_n   = S_PID;
      crc_clear = 1'b1;
    end
    if (crc_clear) shift_enable = 1'b0;
  end

  // Verdict is captured on the eop edge; the residual is already stable then.
  always_comb begin
    vd_n          = '0;
    vd_n.is_data  = w_is_data;
    vd_n.data_pid = w_data_pid;
    vd_n.pid_err  = w_pid_err || (state == S_PID);
    vd_n.len_err  = w_is_data && (ovf || bit_cnt[2:0] != 3'd0 ||
                                  bit_cnt < 14'd16 || bit_cnt > MAX_BITS);
    if (vd_n.is_data && !vd_n.pid_err && !vd_n.len_err) begin
      vd_n.crc_ok  = crc_check_16;
      vd_n.crc_err = !crc_check_16;
    end
    bcnt_n = (bytes_raw > 11'(MAX_BYTES)) ? BCW'(MAX_BYTES) : BCW'(bytes_raw);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      pid_sr     <= '0;
      pid_cnt    <= '0;
      ovf        <= 1'b0;
      w_pid_err  <= 1'b0;
      w_is_data  <= 1'b0;
      w_data_pid <= 1'b0;
      vd         <= '0;
      bcnt       <= '0;
    end else begin
      state <= state_n;
      if (state_n == S_CHECK) begin
        vd   <= vd_n;
        bcnt <= bcnt_n;
      end
      if (bus.sop) begin
        bit_cnt    <= '0;
        pid_sr     <= '0;
        pid_cnt    <= '0;
        ovf        <= 1'b0;
        w_pid_err  <= 1'b0;
        w_is_data  <= 1'b0;
        w_data_pid <= 1'b0;
      end else if (state == S_PID && bit_in) begin
        pid_sr  <= pid_full[7:1];
        pid_cnt <= pid_cnt + 3'd1;
        if (pid_cnt == 3'd7) begin
          w_pid_err  <= !pid_nibble_ok(pid_full);
          w_is_data  <= pid_nibble_ok(pid_full) &&
                        (pid_full == PID_DATA0 || pid_full == PID_DATA1);
          w_data_pid <= (pid_full == PID_DATA1);
        end
      end else if (state == S_DATA && bit_in) begin
        if (bit_cnt != 14'h3FFF) bit_cnt <= bit_cnt + 14'd1;
        if (bit_cnt >= MAX_BITS) ovf <= 1'b1;
      end
    end
  end

  USB_crc_16 u_crc (
    .clk          (clk),
    .n_rst        (~rst),
    .crc_clear    (crc_clear),
    .shift_enable (shift_enable),
    .d_orig       (bus.rx_bit),
    .crc_check_16 (crc_check_16)
  );

  assign bus.pkt_done = (state == S_CHECK);
  assign bus.is_data  = vd.is_data;
  assign bus.data_pid = vd.data_pid;
  assign bus.crc_ok   = vd.crc_ok;
  assign bus.crc_err  = vd.crc_err;
  assign bus.pid_err  = vd.pid_err;
  assign bus.len_err  = vd.len_err;
  assign bus.byte_cnt = bcnt;
endmodule
